mux_rr_scheduler: RTL and testbench

MUX_RR_SCHEDULER -- requirements
Module: mux_rr_scheduler

---
 rtl/mux_sched_pkg.sv | 26 ++
 rtl/rr_pick8.sv | 35 +++
 rtl/mux_rr_scheduler.sv | 148 ++++++++++++++
 tb/tb_mux_rr_scheduler.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// ============================================================================
// Module      : mux_sched_pkg
// Description : Shared widths, state encoding and helpers for mux_rr_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick8.sv
// ============================================================================
// Module      : rr_pick8
// Description : Rotating-priority search: first set req bit from ptr+1, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick8
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset down so the nearest hit (ptr+1) wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_rr_scheduler.sv
// ============================================================================
// Module      : mux_rr_scheduler
// Description : 8-way round-robin scheduler with bounded hold and 8:1 data mux.
//               Optional owner lock enabled by defining MUX_SCHED_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] entrada,
`ifdef MUX_SCHED_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             Z
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             z_q, z_d;

  logic             lock_hold;
  logic             release_now;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

`ifdef MUX_SCHED_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  assign release_now = (state_q == BUSY) &&
                       (!req[sel_q] || ((cnt_q == HOLD_LIM) && !lock_hold));

  // On release the pointer becomes sel, so searching from sel directly
  // yields a same-edge handoff without waiting for ptr_q to update.
  assign pick_ptr = (state_q == BUSY) ? sel_q : ptr_q;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = BUSY;
      BUSY:    if (release_now && !pick_found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d = onehot(pick_idx);
          sel_d = pick_idx;
          cnt_d = CNT_W'(1);
        end else begin
          gnt_d = '0;
          cnt_d = '0;
        end
      end
      BUSY: begin
        z_d     = entrada[sel_q];
        valid_d = 1'b1;
        if (release_now) begin
          ptr_d = sel_q;
          if (pick_found) begin
            gnt_d = onehot(pick_idx);
            sel_d = pick_idx;
            cnt_d = CNT_W'(1);
          end else begin
            gnt_d = '0;
            cnt_d = '0;
          end
        end else if (cnt_q != HOLD_LIM) begin
          // Saturates at the limit while a lock keeps the owner in place.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(N_REQ - 1);
      cnt_q   <= '0;
      valid_q <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      z_q     <= z_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign Z     = z_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_scheduler.sv
// ============================================================================
// Module      : tb_mux_rr_scheduler
// Description : Scoreboard bench for mux_rr_scheduler; lock cases need MUX_SCHED_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] entrada;
  logic       lock_i;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic       Z;

  typedef struct packed {
    logic [95:0] nm;
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic        valid;
    logic        z;
    logic        zchk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 0;

  mux_rr_scheduler #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .entrada (entrada),
`ifdef MUX_SCHED_LOCK_EN
    .lock    (lock_i),
`endif
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .Z       (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic [95:0] nm, input logic rst, input logic [7:0] r,
                      input logic [7:0] e, input logic lk, input logic [7:0] eg,
                      input logic [2:0] es, input logic ev, input logic ez,
                      input logic zc);
    @(negedge clk);
    rst_n   = rst;
    req     = r;
    entrada = e;
    lock_i  = lk;
    exp_q.push_back('{nm: nm, gnt: eg, sel: es, valid: ev, z: ez, zchk: zc});
  endtask

  // Monitor: compare DUT outputs one delta after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (gnt !== e.gnt || sel !== e.sel || valid !== e.valid ||
            (e.zchk && Z !== e.z)) begin
          n_fail++;
          $display("FAIL %0s: got gnt=%h sel=%0d valid=%b Z=%b, expected gnt=%h sel=%0d valid=%b Z=%b%0s",
                   e.nm, gnt, sel, valid, Z, e.gnt, e.sel, e.valid, e.z,
                   e.zchk ? "" : "(unchecked)");
        end
      end
    end
  end

  initial begin
    logic [7:0] one;
    one     = 8'h01;
    rst_n   = 1'b0;
    req     = 8'h00;
    entrada = 8'h00;
    lock_i  = 1'b0;

    step("reset0", 0, 8'hFF, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    step("reset1", 0, 8'hFF, 8'h00, 0, 8'h00, 0, 0, 0, 1);

    for (int k = 0; k <= 32; k++) begin
      step("rr", 1, 8'hFF, 8'h00, 0, one << ((k / 4) % 8), 3'((k / 4) % 8),
           (k > 0), 0, (k > 0));
    end
    step("rr_idle0", 1, 8'h00, 8'h00, 0, 8'h00, 0, 1, 0, 1);
    step("rr_idle1", 1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);

    step("early_a", 1, 8'h24, 8'h00, 0, 8'h04, 2, 0, 0, 0);
    step("early_b", 1, 8'h24, 8'h00, 0, 8'h04, 2, 1, 0, 1);
    step("early_c", 1, 8'h20, 8'h00, 0, 8'h20, 5, 1, 0, 1);
    step("early_d", 1, 8'h00, 8'h00, 0, 8'h00, 5, 1, 0, 1);
    step("early_e", 1, 8'h00, 8'h00, 0, 8'h00, 5, 0, 0, 0);

    step("data_g",  1, 8'h40, 8'h00, 0, 8'h40, 6, 0, 0, 0);
    step("data_z1", 1, 8'h40, 8'h40, 0, 8'h40, 6, 1, 1, 1);
    step("data_z0", 1, 8'h40, 8'h00, 0, 8'h40, 6, 1, 0, 1);
    step("data_rl", 1, 8'h00, 8'hFF, 0, 8'h00, 6, 1, 1, 1);
    step("data_id", 1, 8'h00, 8'h00, 0, 8'h00, 6, 0, 0, 0);

    for (int k = 0; k < 10; k++) begin
      step("single", 1, 8'h80, 8'h80, 0, 8'h80, 7, (k > 0), 1, (k > 0));
    end
    step("single_c3", 1, 8'h81, 8'h80, 0, 8'h80, 7, 1, 1, 1);
    step("single_c4", 1, 8'h81, 8'h80, 0, 8'h80, 7, 1, 1, 1);
    step("single_hd", 1, 8'h81, 8'h80, 0, 8'h01, 0, 1, 1, 1);
    step("single_rl", 1, 8'h00, 8'h00, 0, 8'h00, 0, 1, 0, 1);
    step("single_id", 1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);

    step("wrap_g",  1, 8'h08, 8'h00, 0, 8'h08, 3, 0, 0, 0);
    step("wrap_nb", 1, 8'h0F, 8'h00, 0, 8'h08, 3, 1, 0, 1);
    step("wrap_hd", 1, 8'h07, 8'h00, 0, 8'h01, 0, 1, 0, 1);
    step("wrap_rl", 1, 8'h00, 8'h00, 0, 8'h00, 0, 1, 0, 1);

    step("mrst_g",  1, 8'h18, 8'h00, 0, 8'h08, 3, 0, 0, 0);
    step("mrst_r",  0, 8'h18, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    step("mrst_g2", 1, 8'h18, 8'h00, 0, 8'h08, 3, 0, 0, 1);
    step("mrst_rl", 1, 8'h00, 8'h00, 0, 8'h00, 3, 1, 0, 1);

`ifdef MUX_SCHED_LOCK_EN
    step("lock_rst", 0, 8'h03, 8'h00, 1, 8'h00, 0, 0, 0, 1);
    for (int k = 0; k < 9; k++) begin
      step("lock_hold", 1, 8'h03, 8'h00, 1, 8'h01, 0, (k > 0), 0, 1);
    end
    step("lock_rel", 1, 8'h03, 8'h00, 0, 8'h02, 1, 1, 0, 1);
    step("lock_end", 1, 8'h00, 8'h00, 0, 8'h00, 1, 1, 0, 1);
`endif

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
